// File: rtl/fp32_mul_arb_pkg.sv
// Shared constants and helpers for the fp32 multiplier arbiter slice.
// Defaults here set the top-level parameter values.
package fp32_mul_arb_pkg;

    localparam int FP32_W        = 32;
    localparam int NUM_REQ_DEF   = 4;
    localparam int MUL_LAT_DEF   = 4;
    localparam int MAX_OUTST_DEF = 2;

    localparam logic [3:0] STAT_SEL_STALL = 4'd15;

    function automatic int tag_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/fp32_mul_tag_pipe.sv
// Purpose: valid+tag delay line that tracks operations through the multiplier.
// Latency: DEPTH cycles. Backpressure: none; it shifts every cycle, and rst clears it.
module fp32_mul_tag_pipe #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_vld,
    output logic [TAG_W-1:0] out_tag
);

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
    } ent_t;

    ent_t pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= '{vld: in_vld, tag: in_tag};
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign out_vld = pipe_q[DEPTH-1].vld;
    assign out_tag = pipe_q[DEPTH-1].tag;

endmodule

// File: rtl/fp32_mul_arb.sv
// Purpose: round-robin share of one pipelined fp32 multiplier; optional stats via FP32_MUL_ARB_STATS_EN.
// Latency: handshake to rsp_val is 1 + MUL_LAT cycles.
// Backpressure: req_rdy drops when a requester hits MAX_OUTST in flight; results are never stalled.
module fp32_mul_arb
    import fp32_mul_arb_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int MUL_LAT   = MUL_LAT_DEF,
    parameter int MAX_OUTST = MAX_OUTST_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_val,
    output logic [NUM_REQ-1:0]        req_rdy,
    input  logic [FP32_W*NUM_REQ-1:0] req_x1,
    input  logic [FP32_W*NUM_REQ-1:0] req_x2,
    output logic [FP32_W-1:0]         mul_x1,
    output logic [FP32_W-1:0]         mul_x2,
    output logic                      mul_val,
    input  logic [FP32_W-1:0]         mul_y,
    output logic [NUM_REQ-1:0]        rsp_val,
    output logic [FP32_W-1:0]         rsp_y,
    output logic                      busy
`ifdef FP32_MUL_ARB_STATS_EN
    ,
    input  logic [3:0]                stat_sel,
    output logic [FP32_W-1:0]         stat_data
`endif
);

    localparam int TAG_W = tag_w(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    logic [CNT_W-1:0]   cnt [NUM_REQ];
    logic [TAG_W-1:0]   rr_ptr;
    logic [TAG_W-1:0]   gidx;
    logic [TAG_W-1:0]   iss_tag;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] grant;
    logic               found;
    logic               xfer;
    logic               pipe_vld;
    logic [TAG_W-1:0]   pipe_tag;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            elig[i] = req_val[i] && !rst && (cnt[i] < CNT_W'(MAX_OUTST));
    end

    // First eligible requester at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        grant = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && elig[idx]) begin
                found = 1'b1;
                gidx  = TAG_W'(idx);
            end
        end
        if (found) grant[gidx] = 1'b1;
    end

    assign req_rdy = grant;
    assign xfer    = found;

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_x1  <= '0;
            mul_x2  <= '0;
            mul_val <= 1'b0;
            iss_tag <= '0;
            rr_ptr  <= '0;
        end else begin
            mul_val <= xfer;
            if (xfer) begin
                mul_x1  <= req_x1[int'(gidx)*FP32_W +: FP32_W];
                mul_x2  <= req_x2[int'(gidx)*FP32_W +: FP32_W];
                iss_tag <= gidx;
                rr_ptr  <= (gidx == TAG_W'(NUM_REQ-1)) ? '0 : gidx + TAG_W'(1);
            end
        end
    end

    fp32_mul_tag_pipe #(.DEPTH(MUL_LAT), .TAG_W(TAG_W)) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (mul_val),
        .in_tag  (iss_tag),
        .out_vld (pipe_vld),
        .out_tag (pipe_tag)
    );

    always_comb begin
        rsp_val = '0;
        if (pipe_vld) rsp_val[pipe_tag] = 1'b1;
    end

    assign rsp_y = mul_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                case ({grant[i], rsp_val[i]})
                    2'b10:   cnt[i] <= cnt[i] + CNT_W'(1);
                    2'b01:   cnt[i] <= cnt[i] - CNT_W'(1);
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) busy = busy | (cnt[i] != '0);
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt_chk
        a_no_ovf: assert property (@(posedge clk) disable iff (rst)
            !(grant[gi] && !rsp_val[gi] && cnt[gi] == CNT_W'(MAX_OUTST)));
        a_no_unf: assert property (@(posedge clk) disable iff (rst)
            !(rsp_val[gi] && !grant[gi] && cnt[gi] == '0));
    end

`ifdef FP32_MUL_ARB_STATS_EN
    logic [FP32_W-1:0] grant_cnt [NUM_REQ];
    logic [FP32_W-1:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
            stall_cnt <= '0;
            stat_data <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (grant[i] && grant_cnt[i] != '1) grant_cnt[i] <= grant_cnt[i] + 1'b1;
            if ((|req_val) && !xfer && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (stat_sel < 4'(NUM_REQ))
                stat_data <= grant_cnt[stat_sel[TAG_W-1:0]];
            else if (stat_sel == STAT_SEL_STALL)
                stat_data <= stall_cnt;
            else
                stat_data <= '0;
        end
    end
`else
    // Statistics omitted in this build.
`endif

endmodule

// File: tb/tb_fp32_mul_arb.sv
// Directed bench for fp32_mul_arb with a 4-stage behavioural fp32 multiplier.
module tb_fp32_mul_arb;

    logic         clk;
    logic         rst;
    logic [3:0]   req_val;
    logic [3:0]   req_rdy;
    logic [127:0] req_x1;
    logic [127:0] req_x2;
    logic [31:0]  mul_x1;
    logic [31:0]  mul_x2;
    logic         mul_val;
    logic [31:0]  mul_y;
    logic [3:0]   rsp_val;
    logic [31:0]  rsp_y;
    logic         busy;
`ifdef FP32_MUL_ARB_STATS_EN
    logic [3:0]   stat_sel;
    logic [31:0]  stat_data;
`endif

    int total = 0;
    int bad   = 0;

    localparam logic [3:0] PT_RDY [10] = '{4'b1000, 4'b0010, 4'b0010, 4'b0000, 4'b0000,
                                           4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
    localparam logic [3:0] PT_RSP [10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                           4'b1000, 4'b0010, 4'b0010, 4'b0000, 4'b0000};

    fp32_mul_arb dut (
        .clk      (clk),
        .rst      (rst),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_x1   (req_x1),
        .req_x2   (req_x2),
        .mul_x1   (mul_x1),
        .mul_x2   (mul_x2),
        .mul_val  (mul_val),
        .mul_y    (mul_y),
        .rsp_val  (rsp_val),
        .rsp_y    (rsp_y),
        .busy     (busy)
`ifdef FP32_MUL_ARB_STATS_EN
        ,
        .stat_sel (stat_sel),
        .stat_data(stat_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Normal-number fp32 multiply, truncating; exact for the vectors used here.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] p;
        int          e;
        logic [22:0] m;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        return {s, e[7:0], m};
    endfunction

    logic [31:0] ypipe [4];
    always @(posedge clk) begin
        ypipe[0] <= mul_val ? fmul(mul_x1, mul_x2) : 32'd0;
        for (int i = 1; i < 4; i++) ypipe[i] <= ypipe[i-1];
    end
    assign mul_y = ypipe[3];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        req_val = '0;
`ifdef FP32_MUL_ARB_STATS_EN
        stat_sel = '0;
`endif
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++; if (mul_val !== 1'b0) begin bad++; $display("FAIL reset_mul_val got=%b want=0", mul_val); end
        total++; if (mul_x1 !== 32'd0) begin bad++; $display("FAIL reset_mul_x1 got=%h want=0", mul_x1); end
        total++; if (rsp_val !== 4'd0) begin bad++; $display("FAIL reset_rsp_val got=%b want=0000", rsp_val); end
        total++; if (req_rdy !== 4'd0) begin bad++; $display("FAIL reset_req_rdy got=%b want=0000", req_rdy); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        step();
    endtask

    task automatic test_single_op(input string nm);
        req_x1[31:0] = 32'h3FC0_0000;
        req_x2[31:0] = 32'h4000_0000;
        for (int c = 0; c < 8; c++) begin
            req_val = (c == 0) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            total++; if (req_rdy !== ((c == 0) ? 4'b0001 : 4'b0000)) begin bad++; $display("FAIL %s_rdy c=%0d got=%b", nm, c, req_rdy); end
            total++; if (mul_val !== (c == 1)) begin bad++; $display("FAIL %s_mul_val c=%0d got=%b", nm, c, mul_val); end
            total++; if (busy !== (c >= 1 && c <= 5)) begin bad++; $display("FAIL %s_busy c=%0d got=%b", nm, c, busy); end
            total++; if (rsp_val !== ((c == 5) ? 4'b0001 : 4'b0000)) begin bad++; $display("FAIL %s_rsp_val c=%0d got=%b", nm, c, rsp_val); end
            if (c == 1) begin
                total++; if (mul_x1 !== 32'h3FC0_0000) begin bad++; $display("FAIL %s_mul_x1 got=%h want=3fc00000", nm, mul_x1); end
                total++; if (mul_x2 !== 32'h4000_0000) begin bad++; $display("FAIL %s_mul_x2 got=%h want=40000000", nm, mul_x2); end
            end
            if (c == 5) begin
                total++; if (rsp_y !== 32'h4040_0000) begin bad++; $display("FAIL %s_rsp_y got=%h want=40400000", nm, rsp_y); end
            end
            step();
        end
    endtask

`ifdef FP32_MUL_ARB_STATS_EN
    task automatic read_stat(input logic [3:0] sel, input logic [31:0] want);
        stat_sel = sel;
        step();
        @(negedge clk);
        total++; if (stat_data !== want) begin bad++; $display("FAIL stat sel=%0d got=%0d want=%0d", sel, stat_data, want); end
        step();
    endtask
`endif

    task automatic test_fairness();
        logic [3:0] er;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_x1[i*32 +: 32] = 32'h3F80_0000;
            req_x2[i*32 +: 32] = 32'h4000_0000 | (32'(i) << 20);
        end
        for (int c = 0; c < 27; c++) begin
            req_val = (c < 20) ? 4'b1111 : 4'b0000;
            @(negedge clk);
            er = (c < 20) ? (4'b0001 << (c % 4)) : 4'b0000;
            total++; if (req_rdy !== er) begin bad++; $display("FAIL fair_rdy c=%0d got=%b want=%b", c, req_rdy, er); end
            if (c >= 5 && c <= 24) begin
                total++; if (rsp_val !== (4'b0001 << ((c - 5) % 4))) begin bad++; $display("FAIL fair_rsp_val c=%0d got=%b", c, rsp_val); end
                total++; if (rsp_y !== (32'h4000_0000 | (32'((c - 5) % 4) << 20))) begin bad++; $display("FAIL fair_rsp_y c=%0d got=%h", c, rsp_y); end
            end else begin
                total++; if (rsp_val !== 4'b0000) begin bad++; $display("FAIL fair_rsp_idle c=%0d got=%b", c, rsp_val); end
            end
            step();
        end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fair_busy_end got=%b want=0", busy); end
        step();
`ifdef FP32_MUL_ARB_STATS_EN
        for (int s = 0; s < 4; s++) read_stat(4'(s), 32'd5);
        read_stat(4'd15, 32'd0);
        read_stat(4'd7, 32'd0);
`endif
    endtask

    task automatic test_outst_cap();
        logic [3:0] er;
        do_reset();
        req_x1[64 +: 32] = 32'h3F80_0000;
        req_x2[64 +: 32] = 32'h4120_0000;
        for (int c = 0; c < 12; c++) begin
            req_val = 4'b0100;
            @(negedge clk);
            er = ((c % 6) < 2) ? 4'b0100 : 4'b0000;
            total++; if (req_rdy !== er) begin bad++; $display("FAIL cap_rdy c=%0d got=%b want=%b", c, req_rdy, er); end
            er = (c >= 5 && ((c - 5) % 6) < 2) ? 4'b0100 : 4'b0000;
            total++; if (rsp_val !== er) begin bad++; $display("FAIL cap_rsp_val c=%0d got=%b want=%b", c, rsp_val, er); end
            if (er != 4'b0000) begin
                total++; if (rsp_y !== 32'h4120_0000) begin bad++; $display("FAIL cap_rsp_y c=%0d got=%h want=41200000", c, rsp_y); end
            end
            total++; if (busy !== (c >= 1)) begin bad++; $display("FAIL cap_busy c=%0d got=%b", c, busy); end
            step();
        end
        req_val = 4'b0000;
`ifdef FP32_MUL_ARB_STATS_EN
        read_stat(4'd15, 32'd8);
`endif
        for (int c = 0; c < 7; c++) step();
    endtask

    task automatic test_ptr_skip();
        do_reset();
        req_val = 4'b0010;
        step();
        req_val = 4'b0000;
        for (int c = 0; c < 7; c++) step();
        for (int c = 0; c < 10; c++) begin
            req_val = (c < 2) ? 4'b1010 : 4'b0010;
            @(negedge clk);
            total++; if (req_rdy !== PT_RDY[c]) begin bad++; $display("FAIL ptr_rdy c=%0d got=%b want=%b", c, req_rdy, PT_RDY[c]); end
            total++; if (rsp_val !== PT_RSP[c]) begin bad++; $display("FAIL ptr_rsp_val c=%0d got=%b want=%b", c, rsp_val, PT_RSP[c]); end
            step();
        end
        req_val = 4'b0000;
        for (int c = 0; c < 7; c++) step();
    endtask

    task automatic test_midflight_reset();
        do_reset();
        req_x1[63:0] = {32'h3F80_0000, 32'h3F80_0000};
        req_x2[63:0] = {32'h4080_0000, 32'h4040_0000};
        for (int c = 0; c < 3; c++) begin
            req_val = 4'b0011;
            step();
        end
        req_val = 4'b0000;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 4; c < 9; c++) begin
            @(negedge clk);
            total++; if (rsp_val !== 4'b0000) begin bad++; $display("FAIL mid_rsp_val c=%0d got=%b want=0000", c, rsp_val); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy c=%0d got=%b want=0", c, busy); end
            if (c == 4) begin
                total++; if (mul_val !== 1'b0) begin bad++; $display("FAIL mid_mul_val got=%b want=0", mul_val); end
                total++; if (mul_x1 !== 32'd0) begin bad++; $display("FAIL mid_mul_x1 got=%h want=0", mul_x1); end
            end
            step();
        end
        test_single_op("after_rst");
    endtask

    initial begin
        rst     = 1'b1;
        req_val = '0;
        req_x1  = '0;
        req_x2  = '0;
`ifdef FP32_MUL_ARB_STATS_EN
        stat_sel = '0;
`endif
        test_reset();
        test_single_op("single");
        test_fairness();
        test_outst_cap();
        test_ptr_skip();
        test_midflight_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
